// File: rtl/vga_fb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_fb_arbiter
//  Purpose  : Shares one single-port pixel RAM between display scanout
//             (prefetched into a small FIFO) and a host/drawing writer.
//             Each frame-buffer pixel is replicated over a 2^SCALE_SHIFT
//             square of screen pixels.
//  Options  : FB_PAGE_FLIP_EN - two display pages; page_sel is latched at
//             frame restart and selects the scanout base address.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk_25,
    input  logic              reset,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              bright,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    input  logic              page_sel,
    output logic [2:0]        rgb,
    output logic              underrun
);

    localparam int c_FB_W    = H_ACTIVE >> SCALE_SHIFT;
    localparam int c_FB_H    = V_ACTIVE >> SCALE_SHIFT;
    localparam int c_FB_SIZE = c_FB_W * c_FB_H;
    localparam int c_COL_W   = $clog2(c_FB_W);
    localparam int c_ROW_W   = $clog2(c_FB_H);
    localparam int c_REP_W   = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_OCC_W   = c_CNT_W + 1;
`ifdef FB_PAGE_FLIP_EN
    localparam int c_PAGES   = 2;
`else
    localparam int c_PAGES   = 1;
`endif
    localparam logic [ADDR_W:0]  c_WR_LIMIT  = (ADDR_W+1)'(c_PAGES * c_FB_SIZE);
    localparam logic [9:0]       c_V_RESTART = 10'(V_ACTIVE);
    localparam logic [9:0]       c_H_MASK    = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(c_FB_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(c_FB_H - 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'((1 << SCALE_SHIFT) - 1);

    // Fetch pointers
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_REP_W-1:0] r_rep;
    logic [ADDR_W-1:0]  r_row_addr;   // page base + row * FB_W
    logic               r_done;       // no more fetches until next restart

    // Read pipeline: r_rd_v = read address on the bus, r_ret_v = data returning
    logic               r_rd_v;
    logic               r_ret_v;

    // Scanout FIFO
    logic [2:0]         r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    // Registered outputs
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_we;
    logic [2:0]         r_mem_wdata;
    logic               r_wr_ack;
    logic [2:0]         r_rgb;
    logic               r_underrun;

    logic               w_restart;
    logic [c_OCC_W-1:0] w_occ;
    logic               w_can_fetch;
    logic               w_rd_urgent;
    logic               w_wr_grant;
    logic               w_rd_opp;
    logic               w_rd_issue;
    logic [ADDR_W-1:0]  w_fetch_addr;
    logic [ADDR_W-1:0]  w_page_base;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;

`ifdef FB_PAGE_FLIP_EN
    assign w_page_base = page_sel ? ADDR_W'(c_FB_SIZE) : '0;
`else
    logic  w_unused_page;
    assign w_unused_page = page_sel;
    assign w_page_base   = '0;
`endif

    // Arbitration: urgent read > write > opportunistic read > idle.
    // A write is not re-granted while its ack is out, since the writer's
    // request in that cycle still belongs to the transfer just granted.
    always_comb begin
        w_restart    = (v_count == c_V_RESTART) && (h_count == 10'd0);
        w_occ        = c_OCC_W'(r_count) + c_OCC_W'(r_rd_v) + c_OCC_W'(r_ret_v);
        w_can_fetch  = !r_done && !w_restart;
        w_rd_urgent  = w_can_fetch && (w_occ < c_OCC_W'(2));
        w_wr_grant   = !w_rd_urgent && wr_req && !r_wr_ack;
        w_rd_opp     = !w_rd_urgent && !w_wr_grant && w_can_fetch
                       && (w_occ < c_OCC_W'(FIFO_DEPTH));
        w_rd_issue   = w_rd_urgent || w_rd_opp;
        w_fetch_addr = r_row_addr + ADDR_W'(r_col);
        w_fifo_empty = (r_count == '0);
        w_push       = r_ret_v && !w_restart;
        w_pop        = bright && ((h_count & c_H_MASK) == c_H_MASK) && !w_fifo_empty;
    end

    // Fetch pointer walk: columns, then row repeats, then rows
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_col      <= '0;
            r_row      <= '0;
            r_rep      <= '0;
            r_row_addr <= '0;
            r_done     <= 1'b1;
        end else if (w_restart) begin
            r_col      <= '0;
            r_row      <= '0;
            r_rep      <= '0;
            r_row_addr <= w_page_base;
            r_done     <= 1'b0;
        end else if (w_rd_issue) begin
            if (r_col == c_COL_LAST) begin
                r_col <= '0;
                if (r_rep == c_REP_LAST) begin
                    r_rep <= '0;
                    if (r_row == c_ROW_LAST) begin
                        r_done <= 1'b1;
                    end else begin
                        r_row      <= r_row + c_ROW_W'(1);
                        r_row_addr <= r_row_addr + ADDR_W'(c_FB_W);
                    end
                end else begin
                    r_rep <= r_rep + c_REP_W'(1);
                end
            end else begin
                r_col <= r_col + c_COL_W'(1);
            end
        end
    end

    // RAM port drive and read-pipeline tracking
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_wr_ack    <= 1'b0;
            r_rd_v      <= 1'b0;
            r_ret_v     <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_grant;
            r_rd_v   <= w_rd_issue;
            r_ret_v  <= r_rd_v && !w_restart;
            if (w_rd_issue) begin
                r_mem_we   <= 1'b0;
                r_mem_addr <= w_fetch_addr;
            end else if (w_wr_grant) begin
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
                r_mem_we    <= ({1'b0, wr_addr} < c_WR_LIMIT);
            end else begin
                r_mem_we <= 1'b0;
            end
        end
    end

    // FIFO storage (contents are don't-care while empty)
    always_ff @(posedge clk_25) begin
        if (w_push) begin
            r_fifo[r_wptr] <= mem_rdata;
        end
    end

    // FIFO pointers, pixel output and sticky starvation flag
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rgb      <= '0;
            r_underrun <= 1'b0;
        end else begin
            if (w_restart) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
                if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);
                r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
            if (bright && !w_fifo_empty) begin
                r_rgb <= r_fifo[r_rptr];
            end else begin
                r_rgb <= '0;
            end
            if (bright && w_fifo_empty) begin
                r_underrun <= 1'b1;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign wr_ack    = r_wr_ack;
    assign rgb       = r_rgb;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_fb_arbiter
//  Purpose  : Directed self-checking bench for vga_fb_arbiter. Scan counters
//             are driven directly (restart, short blanking, active lines).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int c_V_ACTIVE = 480;
    localparam int c_FB_W     = 160;

    logic        clk_25 = 1'b0;
    logic        reset;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        bright;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_ack;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [2:0]  mem_wdata;
    logic [2:0]  mem_rdata;
    logic        page_sel;
    logic [2:0]  rgb;
    logic        underrun;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int n_ack   = 0;
    int n_we    = 0;
    bit wrote_100 = 1'b0;

    // RAM model: unwritten locations read as addr[2:0]
    bit       ram_written [0:65535];
    logic [2:0] ram_data  [0:65535];

    vga_fb_arbiter dut (
        .clk_25    (clk_25),
        .reset     (reset),
        .h_count   (h_count),
        .v_count   (v_count),
        .bright    (bright),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .page_sel  (page_sel),
        .rgb       (rgb),
        .underrun  (underrun)
    );

    always #20 clk_25 = ~clk_25;

    // Synchronous single-port RAM, one cycle read latency
    always @(posedge clk_25) begin
        mem_rdata <= ram_written[mem_addr] ? ram_data[mem_addr] : mem_addr[2:0];
        if (mem_we) begin
            ram_written[mem_addr] <= 1'b1;
            ram_data[mem_addr]    <= mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk_25);
        #1;
        if (wr_ack) n_ack++;
        if (mem_we) n_we++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int addr);
        if (wrote_100 && addr == 100) return 32'd5;
        return 32'(addr & 7);
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_addr"},  mem_addr,  0);
        chk({tag, "_we"},    mem_we,    0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_ack"},   wr_ack,    0);
        chk({tag, "_rgb"},   rgb,       0);
        chk({tag, "_undr"},  underrun,  0);
    endtask

    // Frame restart, then verify the first four prefill addresses
    task automatic frame_restart(input int base);
        bright  = 1'b0;
        v_count = 10'(c_V_ACTIVE);
        h_count = 10'd0;
        tick();
        h_count = 10'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("prefill_addr%0d", i), mem_addr, 32'(base + i));
            chk($sformatf("prefill_we%0d", i), mem_we, 0);
        end
        v_count = 10'd490;
        for (int i = 0; i < 30; i++) begin
            h_count = 10'(10 + i);
            tick();
        end
    endtask

    task automatic run_line(input int v, input bit check);
        for (int h = 0; h < 640; h++) begin
            v_count = 10'(v);
            h_count = 10'(h);
            bright  = 1'b1;
            tick();
            if (check) chk($sformatf("rgb_v%0d_h%0d", v, h), rgb,
                           exp_pix((v >> 2) * c_FB_W + (h >> 2)));
        end
        bright = 1'b0;
        for (int h = 640; h < 700; h++) begin
            h_count = 10'(h);
            tick();
        end
    endtask

    task automatic do_write(input string tag, input logic [15:0] a,
                            input logic [2:0] d, input bit exp_we);
        bit          got;
        logic        we_s;
        logic [15:0] addr_s;
        logic [2:0]  data_s;
        got = 1'b0; we_s = 1'b0; addr_s = '0; data_s = '0;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (wr_ack) begin
                got = 1'b1; we_s = mem_we; addr_s = mem_addr; data_s = mem_wdata;
            end
        end
        wr_req = 1'b0;
        chk({tag, "_ack"}, got, 1);
        chk({tag, "_we"},  we_s, exp_we);
        if (exp_we) begin
            chk({tag, "_addr"},  addr_s, a);
            chk({tag, "_wdata"}, data_s, d);
        end
        tick();
        chk({tag, "_ack_pulse"}, wr_ack, 0);
        chk({tag, "_we_off"},    mem_we, 0);
    endtask

    initial begin
        int ack0;
        int we0;
        reset = 1'b1; h_count = '0; v_count = 10'd500; bright = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; page_sel = 1'b0;

        // Power-on reset
        tick(); tick();
        chk_outputs_zero("por");
        reset = 1'b0;

        // First frame: prefill then five checked lines
        frame_restart(0);
        for (int v = 0; v < 5; v++) run_line(v, 1'b1);
        chk("underrun_after_frame", underrun, 0);

        // Reset asserted mid-line for three cycles
        for (int h = 0; h < 100; h++) begin
            v_count = 10'd5; h_count = 10'(h); bright = 1'b1; tick();
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            h_count = h_count + 10'd1;
            tick();
            chk_outputs_zero($sformatf("midrst%0d", i));
        end
        reset = 1'b0; bright = 1'b0;
        we0 = n_we;
        for (int i = 0; i < 10; i++) begin
            h_count = 10'(200 + i);
            tick();
        end
        chk("postrst_idle_addr", mem_addr, 0);
        chk("postrst_no_write", n_we - we0, 0);
        frame_restart(0);

        // Writer holding its request across active lines
        ack0 = n_ack; we0 = n_we;
        wr_req = 1'b1; wr_addr = 16'd100; wr_data = 3'd5; wrote_100 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        for (int v = 0; v < 4; v++) run_line(v, 1'b1);
        wr_req = 1'b0;
        tick();
        chk("hold_acks_seen", (n_ack - ack0) > 20, 1);
        chk("hold_we_per_ack", n_we - we0, n_ack - ack0);
        chk("hold_ram100", ram_data[100], 5);
        chk("hold_underrun", underrun, 0);

        // Single writes at the address limits
        do_write("wr200",   16'd200,   3'd6, 1'b1);
        do_write("wr19199", 16'd19199, 3'd2, 1'b1);
`ifdef FB_PAGE_FLIP_EN
        do_write("wr19200", 16'd19200, 3'd3, 1'b1);
`else
        do_write("wr19200", 16'd19200, 3'd3, 1'b0);
`endif
        do_write("wr38400", 16'd38400, 3'd4, 1'b0);

        // Display page selected at restart
        page_sel = 1'b1;
`ifdef FB_PAGE_FLIP_EN
        frame_restart(19200);
`else
        frame_restart(0);
`endif
        page_sel = 1'b0;

        // Starvation: active video with no fetch running after reset
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        for (int h = 0; h < 8; h++) begin
            v_count = 10'd0; h_count = 10'(h); bright = 1'b1;
            tick();
            chk($sformatf("starve_rgb_h%0d", h), rgb, 0);
            chk($sformatf("starve_undr_h%0d", h), underrun, 1);
        end
        bright = 1'b0; h_count = 10'd640;
        tick();
        chk("starve_blank_rgb", rgb, 0);
        chk("starve_blank_undr", underrun, 1);
        frame_restart(0);
        run_line(0, 1'b1);
        chk("underrun_sticky", underrun, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
